bayer_pattern_gen: RTL and testbench

//  Synthetic Bayer-RAW video source feeding the frame buffer write port (in_0_*), PCNT pixels/clock.

---
 rtl/bayer_pkg.sv | 77 +++++++
 rtl/bayer_pattern_timing.sv | 124 ++++++++++++
 rtl/bayer_pattern_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_bayer_pattern_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// -----------------------------------------------------------------------------
// bayer_pkg
//   Shared types and helpers for the synthetic Bayer-RAW pattern source and
//   for anything that has to interpret its output (e.g. a raw2rgb checker).
//   - mode_e      : pattern selection (HBAR, VBAR, RAMP, AUTO)
//   - bayer_ch_e  : colour channel of one mosaic site (R, G, B)
//   - tstate_e    : timing generator run state
//   - bar_rgb()   : 8-entry colour bar LUT, returns {r,g,b} on/off flags
//   - bayer_ch()  : channel at (row,col) parity for a 4-character pattern
//   - pattern_ok(): true for RGGB / GRBG / GBRG / BGGR
// -----------------------------------------------------------------------------
package bayer_pkg;

  typedef enum logic [1:0] {
    HBAR = 2'd0,
    VBAR = 2'd1,
    RAMP = 2'd2,
    AUTO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    R = 2'd0,
    G = 2'd1,
    B = 2'd2
  } bayer_ch_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tstate_e;

  localparam int XY_W   = 12;
  localparam int FCNT_W = 16;

  // Colour bar LUT: index 0..7 -> {r,g,b}, each component fully on or off.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111; // white
      3'd1:    rgb = 3'b110; // yellow
      3'd2:    rgb = 3'b011; // cyan
      3'd3:    rgb = 3'b010; // green
      3'd4:    rgb = 3'b101; // magenta
      3'd5:    rgb = 3'b100; // red
      3'd6:    rgb = 3'b001; // blue
      default: rgb = 3'b000; // black
    endcase
    return rgb;
  endfunction

  // The pattern string is packed with its first character in the MSBs, so
  // row0col0 lives in [31:24] and row1col1 in [7:0].
  function automatic bayer_ch_e bayer_ch(input logic [31:0] pattern,
                                         input logic        row,
                                         input logic        col);
    logic [7:0] c;
    bayer_ch_e  ch;
    case ({row, col})
      2'b00:   c = pattern[31:24];
      2'b01:   c = pattern[23:16];
      2'b10:   c = pattern[15:8];
      default: c = pattern[7:0];
    endcase
    case (c)
      8'h52:   ch = R;
      8'h42:   ch = B;
      default: ch = G;
    endcase
    return ch;
  endfunction

  function automatic logic pattern_ok(input logic [31:0] pattern);
    return (pattern == "RGGB") || (pattern == "GRBG") ||
           (pattern == "GBRG") || (pattern == "BGGR");
  endfunction

endpackage

// File: rtl/bayer_pattern_timing.sv
// -----------------------------------------------------------------------------
// bayer_pattern_timing
//   Raster timing core: h/v counters plus the IDLE/RUN state machine, and the
//   combinational decode of sync / data-enable / active x,y from that state.
//   The decode is unregistered on purpose: the top registers it together with
//   the pixel data so every output lands in the same clock.
// Ports
//   clk_i, rst_i      clock, async active-high reset
//   en_i              run enable (start from IDLE, continue at frame end)
//   hs_o, vs_o, de_o  sync and active-video decode of the current counters
//   x_o, y_o          active pixel-group / line index, 0 outside active video
//   frame_start_o     counters at h=0,v=0 while running
//   frame_end_o       counters at the last clock of the last line
// -----------------------------------------------------------------------------
module bayer_pattern_timing
  import bayer_pkg::*;
#(
  parameter int H_SYNC = 44,
  parameter int H_BP   = 148,
  parameter int H_ACT  = 480,
  parameter int H_FP   = 88,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 36,
  parameter int V_ACT  = 1080,
  parameter int V_FP   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic            hs_o,
  output logic            vs_o,
  output logic            de_o,
  output logic [XY_W-1:0] x_o,
  output logic [XY_W-1:0] y_o,
  output logic            frame_start_o,
  output logic            frame_end_o
);

  localparam logic [XY_W-1:0] H_LAST  = XY_W'(H_SYNC + H_BP + H_ACT + H_FP - 1);
  localparam logic [XY_W-1:0] V_LAST  = XY_W'(V_SYNC + V_BP + V_ACT + V_FP - 1);
  localparam logic [XY_W-1:0] H_SYNCW = XY_W'(H_SYNC);
  localparam logic [XY_W-1:0] V_SYNCW = XY_W'(V_SYNC);
  localparam logic [XY_W-1:0] H_OFF   = XY_W'(H_SYNC + H_BP);
  localparam logic [XY_W-1:0] V_OFF   = XY_W'(V_SYNC + V_BP);
  localparam logic [XY_W-1:0] H_END   = XY_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [XY_W-1:0] V_END   = XY_W'(V_SYNC + V_BP + V_ACT);

  tstate_e         state_q;
  logic [XY_W-1:0] h_q;
  logic [XY_W-1:0] v_q;
  logic            h_act_s;
  logic            v_act_s;

  // Run state and raster counters. Once running, a frame is always finished;
  // en_i is only looked at on the last clock of the frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          h_q     <= '0;
          v_q     <= '0;
          state_q <= en_i ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (h_q == H_LAST) begin
            h_q <= '0;
            if (v_q == V_LAST) begin
              v_q     <= '0;
              state_q <= en_i ? ST_RUN : ST_IDLE;
            end else begin
              v_q     <= v_q + 12'd1;
              state_q <= ST_RUN;
            end
          end else begin
            h_q     <= h_q + 12'd1;
            v_q     <= v_q;
            state_q <= ST_RUN;
          end
        end
        default: begin
          h_q     <= '0;
          v_q     <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign h_act_s = (h_q >= H_OFF) && (h_q < H_END);
  assign v_act_s = (v_q >= V_OFF) && (v_q < V_END);

  // Region decode of the current counter state; everything is zero in IDLE.
  always_comb begin
    hs_o          = 1'b0;
    vs_o          = 1'b0;
    de_o          = 1'b0;
    x_o           = '0;
    y_o           = '0;
    frame_start_o = 1'b0;
    frame_end_o   = 1'b0;
    if (state_q == ST_RUN) begin
      hs_o          = (h_q < H_SYNCW);
      vs_o          = (v_q < V_SYNCW);
      de_o          = h_act_s && v_act_s;
      frame_start_o = (h_q == 12'd0) && (v_q == 12'd0);
      frame_end_o   = (h_q == H_LAST) && (v_q == V_LAST);
      if (h_act_s && v_act_s) begin
        x_o = h_q - H_OFF;
        y_o = v_q - V_OFF;
      end else begin
        x_o = '0;
        y_o = '0;
      end
    end else begin
      hs_o = 1'b0;
      vs_o = 1'b0;
    end
  end

endmodule

// File: rtl/bayer_pattern_gen.sv
// -----------------------------------------------------------------------------
// bayer_pattern_gen
//   Synthetic Bayer-RAW video source: self-timed raster with colour bars
//   (horizontal or vertical) or a ramp, mosaicked per PATTERN, PCNT pixels
//   per clock (lane 0 in the LSBs is the leftmost pixel).
// Ports
//   i_pclk, i_rst   pixel clock, async active-high reset (release synchronised)
//   i_en            run enable; a started frame always completes
//   i_mode          0 hbar, 1 vbar, 2 ramp, 3 auto (hbar even / vbar odd frame)
//   o_x, o_y        active pixel-group and line index, 0 outside active video
//   o_valid, o_de   active video (identical, no gaps)
//   o_hs, o_vs      syncs, active-high
//   o_raw           PCNT raw pixels of PW bits, 0 outside active video
//   o_sof           one-clock pulse with the first active pixel group
//   o_frame_cnt     completed frames, wraps
// -----------------------------------------------------------------------------
module bayer_pattern_gen
  import bayer_pkg::*;
#(
  parameter int          PW      = 8,
  parameter int          PCNT    = 4,
  parameter int          H_SYNC  = 44,
  parameter int          H_BP    = 148,
  parameter int          H_ACT   = 480,
  parameter int          H_FP    = 88,
  parameter int          V_SYNC  = 5,
  parameter int          V_BP    = 36,
  parameter int          V_ACT   = 1080,
  parameter int          V_FP    = 4,
  parameter logic [31:0] PATTERN = "GBRG",
  parameter int          BAR_SHX = 4,
  parameter int          BAR_SHY = 5
) (
  input  logic               i_pclk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [1:0]         i_mode,
  output logic [11:0]        o_x,
  output logic [11:0]        o_y,
  output logic               o_valid,
  output logic               o_de,
  output logic               o_hs,
  output logic               o_vs,
  output logic [PW*PCNT-1:0] o_raw,
  output logic               o_sof,
  output logic [15:0]        o_frame_cnt
);

  if (!pattern_ok(PATTERN)) begin : g_bad_pattern
    $error("bayer_pattern_gen: PATTERN must be RGGB, GRBG, GBRG or BGGR");
  end
  if (BAR_SHX < 0 || BAR_SHX > XY_W - 3 || BAR_SHY < 0 || BAR_SHY > XY_W - 3) begin : g_bad_shift
    $error("bayer_pattern_gen: BAR_SHX/BAR_SHY out of range");
  end
  // The mode latch relies on frame start falling in vertical sync, never in
  // active video; counters are XY_W bits wide.
  if (V_SYNC < 1 || H_SYNC < 1 || PW < 1 || PCNT < 1 ||
      H_SYNC + H_BP + H_ACT + H_FP > (1 << XY_W) ||
      V_SYNC + V_BP + V_ACT + V_FP > (1 << XY_W)) begin : g_bad_timing
    $error("bayer_pattern_gen: unsupported timing or pixel geometry");
  end

  logic [1:0]         rst_sync_q;
  logic               rst_s;
  logic               hs_s;
  logic               vs_s;
  logic               de_s;
  logic [XY_W-1:0]    x_s;
  logic [XY_W-1:0]    y_s;
  logic               frame_start_s;
  logic               frame_end_s;
  mode_e              mode_q;
  mode_e              mode_d;
  logic [FCNT_W-1:0]  frame_cnt_q;
  logic [2:0]         bar_idx_s;
  logic [2:0]         rgb_s;
  logic [PW*PCNT-1:0] raw_d;
  logic               sof_d;
  logic               hs_q;
  logic               vs_q;
  logic               de_q;
  logic               valid_q;
  logic               sof_q;
  logic [XY_W-1:0]    x_q;
  logic [XY_W-1:0]    y_q;
  logic [PW*PCNT-1:0] raw_q;

  // Reset bridge: asserts immediately, releases two clock edges later.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end
  assign rst_s = rst_sync_q[1];

  bayer_pattern_timing #(
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP)
  ) u_timing (
    .clk_i         (i_pclk),
    .rst_i         (rst_s),
    .en_i          (i_en),
    .hs_o          (hs_s),
    .vs_o          (vs_s),
    .de_o          (de_s),
    .x_o           (x_s),
    .y_o           (y_s),
    .frame_start_o (frame_start_s),
    .frame_end_o   (frame_end_s)
  );

  // AUTO is resolved when latched, so the pixel path only sees HBAR/VBAR/RAMP.
  // frame_cnt_q has already advanced for the frame that is starting.
  always_comb begin
    mode_d = mode_e'(i_mode);
    case (mode_e'(i_mode))
      AUTO:    mode_d = frame_cnt_q[0] ? VBAR : HBAR;
      default: mode_d = mode_e'(i_mode);
    endcase
  end

  // Mode latch, updated only at frame start so a frame never mixes patterns.
  always_ff @(posedge i_pclk or posedge rst_s) begin
    if (rst_s) begin
      mode_q <= HBAR;
    end else if (frame_start_s) begin
      mode_q <= mode_d;
    end else begin
      mode_q <= mode_q;
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge i_pclk or posedge rst_s) begin
    if (rst_s) begin
      frame_cnt_q <= '0;
    end else if (frame_end_s) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign bar_idx_s = (mode_q == VBAR) ? y_s[BAR_SHY +: 3] : x_s[BAR_SHX +: 3];
  assign rgb_s     = bar_rgb(bar_idx_s);

  // Pixel formatter, one lane per pixel of the group. With PCNT even every
  // group starts on an even column, so lane parity alone gives the column.
  for (genvar k = 0; k < PCNT; k++) begin : g_lane
    localparam logic LANE_COL = ((k % 2) != 0);
    bayer_ch_e     ch_s;
    logic [PW-1:0] ramp_s;
    logic [PW-1:0] lane_s;

    assign ch_s   = bayer_ch(PATTERN, y_s[0], LANE_COL);
    // Truncating before the arithmetic keeps the result mod 2^PW.
    assign ramp_s = PW'(x_s) * PW'(PCNT) + PW'(k) + PW'(y_s);

    // Lane value: bar component or ramp, forced to 0 outside active video.
    always_comb begin
      lane_s = '0;
      if (de_s) begin
        case (mode_q)
          HBAR, VBAR: begin
            case (ch_s)
              R:       lane_s = {PW{rgb_s[2]}};
              G:       lane_s = {PW{rgb_s[1]}};
              B:       lane_s = {PW{rgb_s[0]}};
              default: lane_s = '0;
            endcase
          end
          RAMP:    lane_s = ramp_s;
          default: lane_s = '0;
        endcase
      end else begin
        lane_s = '0;
      end
    end

    assign raw_d[k*PW +: PW] = lane_s;
  end

  assign sof_d = de_s && (x_s == 12'd0) && (y_s == 12'd0);

  // Output register stage: every output one clock after the counter state.
  always_ff @(posedge i_pclk or posedge rst_s) begin
    if (rst_s) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      raw_q   <= '0;
    end else begin
      hs_q    <= hs_s;
      vs_q    <= vs_s;
      de_q    <= de_s;
      valid_q <= de_s;
      sof_q   <= sof_d;
      x_q     <= x_s;
      y_q     <= y_s;
      raw_q   <= raw_d;
    end
  end

  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_de        = de_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_raw       = raw_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bayer_pattern_gen.sv
module tb_bayer_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_valid;
  logic        o_de;
  logic        o_hs;
  logic        o_vs;
  logic [31:0] o_raw;
  logic        o_sof;
  logic [15:0] o_frame_cnt;

  int tests = 0;
  int fails = 0;
  int exp_frames = 0;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] raw;
    logic        sof;
  } pix_t;

  pix_t sb_q[$];
  pix_t mon_p;

  always #5 clk = ~clk;

  bayer_pattern_gen #(
    .PW(8), .PCNT(4),
    .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .PATTERN("GBRG"), .BAR_SHX(0), .BAR_SHY(0)
  ) dut (
    .i_pclk(clk), .i_rst(rst), .i_en(en), .i_mode(mode),
    .o_x(o_x), .o_y(o_y), .o_valid(o_valid), .o_de(o_de),
    .o_hs(o_hs), .o_vs(o_vs), .o_raw(o_raw), .o_sof(o_sof),
    .o_frame_cnt(o_frame_cnt)
  );

  // Reference: bar colours as {r,g,b}; GBRG mosaic written out as a table.
  function automatic logic [31:0] model_raw(int m, int x, int y);
    logic [31:0] r;
    logic [2:0]  rgb;
    int          idx;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (m == 2) begin
        r[k*8 +: 8] = 8'((x * 4 + k + y) % 256);
      end else begin
        idx = (m == 0) ? (x % 8) : (y % 8);
        case (idx)
          0: rgb = 3'b111; 1: rgb = 3'b110; 2: rgb = 3'b011; 3: rgb = 3'b010;
          4: rgb = 3'b101; 5: rgb = 3'b100; 6: rgb = 3'b001; default: rgb = 3'b000;
        endcase
        if (y % 2 == 0) r[k*8 +: 8] = (k % 2 == 0) ? {8{rgb[1]}} : {8{rgb[0]}}; // G B
        else            r[k*8 +: 8] = (k % 2 == 0) ? {8{rgb[2]}} : {8{rgb[1]}}; // R G
      end
    end
    return r;
  endfunction

  task automatic push_frame(int m);
    pix_t p;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        p.x = x; p.y = y; p.raw = model_raw(m, x, y); p.sof = (x == 0 && y == 0);
        sb_q.push_back(p);
      end
    end
  endtask

  // Scoreboard monitor: every valid group is matched against the queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      tests++;
      if (o_valid !== o_de) begin
        fails++;
        $display("FAIL valid_eq_de: o_valid=%b o_de=%b", o_valid, o_de);
      end
      tests++;
      if (o_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got x=%0d y=%0d raw=%h, expected none", o_x, o_y, o_raw);
        end else begin
          mon_p = sb_q.pop_front();
          if ({o_x, o_y, o_raw, o_sof} !== {12'(mon_p.x), 12'(mon_p.y), mon_p.raw, mon_p.sof}) begin
            fails++;
            $display("FAIL sb_pixel: got x=%0d y=%0d raw=%h sof=%b, expected x=%0d y=%0d raw=%h sof=%b",
                     o_x, o_y, o_raw, o_sof, mon_p.x, mon_p.y, mon_p.raw, mon_p.sof);
          end
        end
      end else if (o_raw !== 32'h0 || o_sof !== 1'b0) begin
        fails++;
        $display("FAIL blank_zero: raw=%h sof=%b, expected 0 outside active", o_raw, o_sof);
      end
    end
  end

  task automatic test_reset();
    bit seen = 0;
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    tests++;
    if ({o_hs, o_vs, o_de, o_valid, o_sof, o_x, o_y, o_raw, o_frame_cnt} !== 78'h0) begin
      fails++; $display("FAIL reset_state: outputs not all zero (raw=%h vs=%b)", o_raw, o_vs);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    push_frame(0);
    en = 1'b1;
    @(negedge clk);
    tests++;
    if (o_vs !== 1'b0) begin fails++; $display("FAIL vs_pre_run: got %b expected 0", o_vs); end
    @(negedge clk);
    tests++;
    if (o_vs !== 1'b1 || o_hs !== 1'b1) begin
      fails++; $display("FAIL vs_first: got vs=%b hs=%b expected 1 1", o_vs, o_hs);
    end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_de === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL de_timeout: no active video within 100 clocks"); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({o_hs, o_vs, o_de, o_valid, o_sof, o_x, o_y, o_raw, o_frame_cnt} !== 78'h0) begin
      fails++; $display("FAIL reset_async: got raw=%h de=%b, expected all zero", o_raw, o_de);
    end
    en = 1'b0;
    sb_q.delete();
    exp_frames = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hbar();
    bit seen_a = 0, seen_b = 0;
    int sofs = 0;
    push_frame(0); mode = 2'd0; en = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (o_sof === 1'b1) begin sofs++; en = 1'b0; end
      if (o_de === 1'b1 && o_y == 12'd0 && o_x == 12'd1) begin
        seen_a = 1; tests++;
        if (o_raw !== 32'h00FF00FF) begin fails++; $display("FAIL hbar_y0x1: got %h expected 00ff00ff", o_raw); end
      end
      if (o_de === 1'b1 && o_y == 12'd1 && o_x == 12'd1) begin
        seen_b = 1; tests++;
        if (o_raw !== 32'hFFFFFFFF) begin fails++; $display("FAIL hbar_y1x1: got %h expected ffffffff", o_raw); end
      end
    end
    exp_frames++;
    tests++;
    if (!(seen_a && seen_b) || sofs != 1 || sb_q.size() != 0) begin
      fails++; $display("FAIL hbar_frame: seen=%0d%0d sofs=%0d left=%0d expected 11 1 0", seen_a, seen_b, sofs, sb_q.size());
    end
    tests++;
    if (o_frame_cnt !== 16'(exp_frames) || {o_hs, o_vs, o_de, o_raw} !== 35'h0) begin
      fails++; $display("FAIL hbar_end: frame_cnt=%0d vs=%b expected %0d idle", o_frame_cnt, o_vs, exp_frames);
    end
  endtask

  task automatic test_ramp();
    bit seen = 0;
    push_frame(2); mode = 2'd2; en = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (o_sof === 1'b1) en = 1'b0;
      if (o_de === 1'b1 && o_y == 12'd1 && o_x == 12'd2) begin
        seen = 1; tests++;
        if (o_raw !== 32'h0C0B0A09) begin fails++; $display("FAIL ramp_y1x2: got %h expected 0c0b0a09", o_raw); end
      end
    end
    exp_frames++;
    tests++;
    if (!seen || sb_q.size() != 0 || o_frame_cnt !== 16'(exp_frames)) begin
      fails++; $display("FAIL ramp_frame: seen=%0d left=%0d frame_cnt=%0d expected 1 0 %0d", seen, sb_q.size(), o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_auto();
    int sofs = 0, incs = 0;
    logic [15:0] prev;
    mode = 2'd3;
    push_frame((exp_frames % 2 == 0) ? 0 : 1);
    push_frame(((exp_frames + 1) % 2 == 0) ? 0 : 1);
    prev = o_frame_cnt;
    en = 1'b1;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (o_sof === 1'b1) begin sofs++; if (sofs == 2) en = 1'b0; end
      if (o_frame_cnt !== prev) begin
        incs++; tests++;
        if (o_frame_cnt !== prev + 16'd1) begin
          fails++; $display("FAIL auto_cnt_step: got %0d expected %0d", o_frame_cnt, prev + 16'd1);
        end
        prev = o_frame_cnt;
      end
    end
    exp_frames += 2;
    tests++;
    if (sofs != 2 || incs != 2 || sb_q.size() != 0 || o_frame_cnt !== 16'(exp_frames)) begin
      fails++; $display("FAIL auto_frames: sofs=%0d incs=%0d left=%0d cnt=%0d expected 2 2 0 %0d",
                        sofs, incs, sb_q.size(), o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back_mode_change();
    int sofs = 0;
    mode = 2'd0;
    push_frame(0);
    push_frame(1);
    en = 1'b1;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (o_sof === 1'b1) begin
        sofs++;
        if (sofs == 1) mode = 2'd1;
        if (sofs == 2) en = 1'b0;
      end
    end
    exp_frames += 2;
    tests++;
    if (sofs != 2 || sb_q.size() != 0 || o_frame_cnt !== 16'(exp_frames)) begin
      fails++; $display("FAIL mode_change: sofs=%0d left=%0d cnt=%0d expected 2 0 %0d", sofs, sb_q.size(), o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_en_drop();
    bit dropped = 0;
    int bad_idle = 0;
    mode = 2'd2;
    push_frame(2);
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!dropped && o_de === 1'b1 && o_y == 12'd2) begin en = 1'b0; dropped = 1; end
    end
    exp_frames++;
    tests++;
    if (!dropped || sb_q.size() != 0 || o_frame_cnt !== 16'(exp_frames)) begin
      fails++; $display("FAIL en_drop_frame: dropped=%0d left=%0d cnt=%0d expected 1 0 %0d", dropped, sb_q.size(), o_frame_cnt, exp_frames);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({o_hs, o_vs, o_de, o_valid, o_sof, o_raw} !== 37'h0 || o_frame_cnt !== 16'(exp_frames)) bad_idle++;
    end
    tests++;
    if (bad_idle != 0) begin
      fails++; $display("FAIL en_drop_idle: %0d non-idle clocks, expected 0", bad_idle);
    end
  endtask

  initial begin
    test_reset();
    test_hbar();
    test_ramp();
    test_auto();
    test_back_to_back_mode_change();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
